// File: rtl/psys_route_pkg.sv
`default_nettype none
// ==== psys_route_pkg : shared widths and helpers for the packing/routing datapath ====
// Rev 1.0
package psys_route_pkg;

  localparam int PSYS_IN_W  = 128;
  localparam int PSYS_RATIO = 12;
  localparam int PSYS_OUT_W = PSYS_IN_W * PSYS_RATIO;

  // Width of a lane index; never narrower than one bit so RATIO=1 still elaborates.
  function automatic int lane_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ==== axis_out_reg : single-entry AXI-stream output register with pass-through ready ====
// Rev 1.0
module axis_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         m_tready_i,
  output logic         m_tvalid_o,
  output logic [W-1:0] m_tdata_o,
  output logic         m_tlast_o,
  output logic         ready_o
);

  logic         valid_q;
  logic         last_q;
  logic [W-1:0] data_q;

  // Space exists when empty or when the current word leaves this cycle.
  assign ready_o = !valid_q || m_tready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      last_q  <= last_i;
      data_q  <= data_i;
    end else if (m_tready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign m_tvalid_o = valid_q;
  assign m_tdata_o  = data_q;
  assign m_tlast_o  = last_q;

endmodule
`default_nettype wire

// File: rtl/beat_packer.sv
`default_nettype none
// ==== beat_packer : packs RATIO IN_W-bit beats (LSB lane first) into one output word ====
// Rev 1.0 | option BEAT_PACKER_FLUSH_EN: s_tlast closes a short word, zero-filled, m_tlast=1
module beat_packer
  import psys_route_pkg::*;
#(
  parameter int IN_W  = PSYS_IN_W,
  parameter int RATIO = PSYS_RATIO
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IN_W-1:0]               s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic                          s_tlast,
  output logic [IN_W*RATIO-1:0]         m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [lane_idx_w(RATIO)-1:0]  beat_cnt
);

  localparam int            OUT_W     = IN_W * RATIO;
  localparam int            CW        = lane_idx_w(RATIO);
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [OUT_W-1:0] acc_q, acc_d, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept, close, close_last;

  assign accept = s_tvalid && s_tready;

`ifdef BEAT_PACKER_FLUSH_EN
  assign close_last = s_tlast;
`else
  logic unused_tlast;
  assign unused_tlast = s_tlast;
  assign close_last   = 1'b0;
`endif

  assign close = accept && ((cnt_q == LAST_LANE) || close_last);

  // Lanes above the current beat are already zero, since the accumulator clears on every close.
  always_comb begin
    word_d = acc_q;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_q == CW'(k)) word_d[k*IN_W +: IN_W] = s_tdata;
    end
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      if (close) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = word_d;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  axis_out_reg #(
    .W (OUT_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (close),
    .data_i     (word_d),
    .last_i     (close_last),
    .m_tready_i (m_tready),
    .m_tvalid_o (m_tvalid),
    .m_tdata_o  (m_tdata),
    .m_tlast_o  (m_tlast),
    .ready_o    (s_tready)
  );

  assign beat_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_beat_packer.sv
`default_nettype none
// ==== tb_beat_packer : directed and random scoreboard bench for beat_packer ====
// Rev 1.0
module tb_beat_packer;

  localparam int IN_W  = 128;
  localparam int RATIO = 12;
  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = 4;
`ifdef BEAT_PACKER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic [IN_W-1:0]  s_tdata  = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tlast  = 1'b0;
  logic             s_tready;
  logic [OUT_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic             m_tlast;
  logic [CW-1:0]    beat_cnt;

  beat_packer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } word_t;

  word_t            exp_q[$];
  logic [OUT_W-1:0] mdl_acc    = '0;
  int               mdl_cnt    = 0;
  int               errors     = 0;
  int               checks     = 0;
  int               words_seen = 0;
  bit               rand_en    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bad_lane(input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] b);
    for (int k = 0; k < RATIO; k++)
      if (a[k*IN_W +: IN_W] !== b[k*IN_W +: IN_W]) return k;
    return 0;
  endfunction

  task automatic chk_word(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    int ln;
    checks++;
    assert (obs === exp) else begin
      errors++;
      ln = bad_lane(obs, exp);
      $error("FAIL %s lane=%0d observed=%0h expected=%0h", tag, ln,
             obs[ln*IN_W +: IN_W], exp[ln*IN_W +: IN_W]);
    end
  endtask

  task automatic model_accept(input logic [IN_W-1:0] d, input logic l);
    word_t w;
    mdl_acc[mdl_cnt*IN_W +: IN_W] = d;
    if (mdl_cnt == RATIO - 1 || (FLUSH && l)) begin
      w.data = mdl_acc;
      w.last = FLUSH && l;
      exp_q.push_back(w);
      mdl_acc = '0;
      mdl_cnt = 0;
    end else begin
      mdl_cnt++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [IN_W-1:0] d, input logic l, output int stalls);
    stalls   = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && stalls < 300) begin
      stalls++;
      @(negedge clk);
    end
    if (s_tready) begin
      model_accept(d, l);
    end else begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    mdl_acc = '0;
    mdl_cnt = 0;
  endtask

  always @(negedge clk) begin : mon
    word_t w;
    if (rst_n && m_tvalid && m_tready) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_word observed=1 expected=0");
      end else begin
        w = exp_q.pop_front();
        chk_word("word_data", m_tdata, w.data);
        chk("word_last", 32'(m_tlast), 32'(w.last));
      end
    end
  end

  initial begin
    int               st;
    int               total_st;
    int               w0;
    logic [OUT_W-1:0] expw;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd1);
    chk_word("rst_m_tdata", m_tdata, '0);
    @(posedge clk);
    #1;

    // Twelve beats 1..12, lane k = k+1, one-cycle valid pulse.
    w0   = words_seen;
    expw = '0;
    for (int k = 0; k < RATIO; k++) begin
      chk("t030_cnt", 32'(beat_cnt), 32'(k));
      expw[k*IN_W +: IN_W] = IN_W'(k + 1);
      send_beat(IN_W'(k + 1), 1'b0, st);
      chk("t030_valid", 32'(m_tvalid), 32'((k == RATIO - 1) ? 1 : 0));
    end
    chk("t030_cnt_wrap", 32'(beat_cnt), 32'd0);
    chk_word("t030_word", m_tdata, expw);
    @(posedge clk);
    #1;
    chk("t030_pulse_end", 32'(m_tvalid), 32'd0);
    chk("t030_words", 32'(words_seen - w0), 32'd1);

    // 24 back-to-back beats, no stalls.
    w0       = words_seen;
    total_st = 0;
    for (int k = 0; k < 2 * RATIO; k++) begin
      send_beat(IN_W'(32'hA000 + k), 1'b0, st);
      total_st += st;
    end
    chk("t031_stalls", 32'(total_st), 32'd0);
    @(posedge clk);
    #1;
    chk("t031_words", 32'(words_seen - w0), 32'd2);

    // Backpressure for 5 cycles with a complete word held.
    m_tready = 1'b0;
    w0       = words_seen;
    expw     = '0;
    for (int k = 0; k < RATIO; k++) begin
      expw[k*IN_W +: IN_W] = IN_W'(32'h100 + k);
      send_beat(IN_W'(32'h100 + k), 1'b0, st);
    end
    chk("t032_valid", 32'(m_tvalid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t032_s_tready", 32'(s_tready), 32'd0);
      chk("t032_hold_valid", 32'(m_tvalid), 32'd1);
      chk_word("t032_hold_data", m_tdata, expw);
      @(posedge clk);
      #1;
    end
    chk("t032_no_xfer", 32'(words_seen - w0), 32'd0);
    m_tready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("t032_xfer", 32'(words_seen - w0), 32'd1);
    chk("t032_valid_fall", 32'(m_tvalid), 32'd0);

    // Five beats, s_tlast on the fifth.
    w0   = words_seen;
    expw = '0;
    for (int k = 0; k < 5; k++) begin
      expw[k*IN_W +: IN_W] = IN_W'(32'h50 + k);
      send_beat(IN_W'(32'h50 + k), (k == 4), st);
    end
`ifdef BEAT_PACKER_FLUSH_EN
    chk("t033_valid", 32'(m_tvalid), 32'd1);
    chk("t033_last", 32'(m_tlast), 32'd1);
    chk("t033_cnt", 32'(beat_cnt), 32'd0);
    chk_word("t033_word", m_tdata, expw);
`else
    chk("t033_valid", 32'(m_tvalid), 32'd0);
    chk("t033_cnt", 32'(beat_cnt), 32'd5);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("t033_words", 32'(words_seen - w0), 32'(FLUSH ? 1 : 0));

    // Reset mid-word discards the partial word.
    apply_reset();
    for (int k = 0; k < 7; k++) send_beat(IN_W'(32'h70 + k), 1'b0, st);
    chk("t034_cnt_pre", 32'(beat_cnt), 32'd7);
    w0 = words_seen;
    apply_reset();
    chk("t034_cnt_rst", 32'(beat_cnt), 32'd0);
    chk("t034_valid_rst", 32'(m_tvalid), 32'd0);
    chk("t034_ready_rst", 32'(s_tready), 32'd1);
    expw = '0;
    for (int k = 0; k < RATIO; k++) begin
      expw[k*IN_W +: IN_W] = IN_W'(32'hC0 + k);
      send_beat(IN_W'(32'hC0 + k), 1'b0, st);
    end
    chk_word("t034_clean_word", m_tdata, expw);
    @(posedge clk);
    #1;
    chk("t034_words", 32'(words_seen - w0), 32'd1);

    // Random valid/ready over 1200 beats.
    w0      = words_seen;
    rand_en = 1'b1;
    fork
      begin
        while (rand_en) begin
          @(posedge clk);
          #1 m_tready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int b = 0; b < 100 * RATIO; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, st);
    end
    rand_en = 1'b0;
    repeat (2) @(posedge clk);
    #2 m_tready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    chk("t035_pending", 32'(exp_q.size()), 32'd0);
    chk("t035_words", 32'(words_seen - w0), 32'd100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/beat_packer.md
BEAT_PACKER -- requirements
Module: beat_packer

Interface
REQ-001 The parameter IN_W SHALL default to 128 and SHALL set the input beat width in bits.
REQ-002 The parameter RATIO SHALL default to 12 and SHALL set the number of input beats per output word (OUT_W = IN_W*RATIO = 1536).
REQ-003 The port clk SHALL be an input, 1 bit wide, and SHALL be the clock; all logic SHALL be rising-edge.
REQ-004 The port rst_n SHALL be an input, 1 bit wide, and SHALL be the synchronous, active-low reset.
REQ-005 The port s_tdata SHALL be an input, IN_W bits wide, carrying the input beat.
REQ-006 The ports s_tvalid (input, 1), s_tready (output, 1) and s_tlast (input, 1) SHALL form the input stream handshake and end-of-frame marker.
REQ-007 The port m_tdata SHALL be an output, OUT_W bits wide, carrying the packed word that feeds a data_route 1536-bit input.
REQ-008 The ports m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1) SHALL form the output stream handshake and end-of-frame marker.
REQ-009 The port beat_cnt SHALL be an output, $clog2(RATIO) bits wide, giving the number of beats currently held in the accumulator.

Function
REQ-010 An input transfer SHALL occur when s_tvalid and s_tready are both 1; an output transfer SHALL occur when m_tvalid and m_tready are both 1.
REQ-011 s_tready SHALL equal (!m_tvalid || m_tready), so that 1 beat per cycle is sustained when m_tready is held at 1.
REQ-012 The k-th accepted beat of a word (k = 0..RATIO-1) SHALL be placed in accumulator bits [k*IN_W +: IN_W], LSB lane first.
REQ-013 On each accepted beat with beat_cnt < RATIO-1 (and no flush), beat_cnt SHALL increment by 1.
REQ-014 On an accepted beat with beat_cnt == RATIO-1, the complete word SHALL be loaded into the output register, m_tvalid SHALL be 1 on the next cycle, and beat_cnt SHALL wrap to 0.
REQ-015 Latency from acceptance of the final beat to m_tvalid = 1 SHALL be exactly 1 cycle.
REQ-016 While m_tvalid = 1 and m_tready = 0, m_tdata, m_tlast and m_tvalid SHALL hold stable and no input beat SHALL be accepted.
REQ-017 When the output register is loaded in the same cycle as an output transfer, the new word SHALL replace the old one with no bubble.
REQ-018 m_tvalid SHALL fall to 0 the cycle after an output transfer if no new word was loaded.
REQ-019 m_tlast SHALL be 0 for every word not closed by a flush (see REQ-024).

Reset
REQ-020 While rst_n = 0 at a clock edge, m_tvalid, m_tlast and beat_cnt SHALL become 0 and s_tready SHALL be 1 on the following cycle.
REQ-021 m_tdata and the accumulator contents SHALL be 0 after reset.
REQ-022 Reset asserted mid-word SHALL discard the partial accumulator and any pending output word without emitting them.

Configuration
REQ-023 The block SHALL implement one compile-time option controlled by the macro BEAT_PACKER_FLUSH_EN.
REQ-024 With BEAT_PACKER_FLUSH_EN defined, an accepted beat with s_tlast = 1 SHALL close the word at that beat: unfilled lanes SHALL be zero, m_tlast SHALL be 1, and beat_cnt SHALL return to 0.
REQ-025 With BEAT_PACKER_FLUSH_EN defined, s_tlast on beat RATIO-1 SHALL produce a full word with m_tlast = 1.
REQ-026 Without BEAT_PACKER_FLUSH_EN, s_tlast SHALL be ignored, only full words SHALL be emitted, and m_tlast SHALL be tied to 0.

Structure
REQ-027 The defaults for IN_W, RATIO and OUT_W, together with the lane-index width function, SHALL reside in the shared package psys_route_pkg.
REQ-028 The output register and its handshake SHALL be a sub-module named axis_out_reg.
REQ-029 The accumulator and counter SHALL remain in beat_packer.

Verification
REQ-030 Twelve beats 0x1..0xC with m_tready = 1 -> one word with lane k = k+1, m_tvalid pulsed exactly 1 cycle after beat 12, beat_cnt sequence 0..11,0.
REQ-031 24 back-to-back beats with m_tready = 1 -> two words on consecutive-word boundaries and s_tready held at 1 throughout.
REQ-032 Word complete and m_tready = 0 for 5 cycles -> m_tdata stable, s_tready = 0 for those 5 cycles, transfer on the first cycle m_tready = 1.
REQ-033 (FLUSH_EN) 5 beats with s_tlast on the 5th -> lanes 0..4 valid, lanes 5..11 zero, m_tlast = 1; (no FLUSH_EN) same stimulus -> no output and beat_cnt = 5.
REQ-034 rst_n = 0 for 1 cycle after 7 beats -> beat_cnt = 0 and no word emitted; the next 12 beats -> a clean word.
REQ-035 Random s_tvalid/m_tready toggling over 1200 beats -> 100 words matching the reference model bit-exactly.
